alu_rr_sched: RTL and testbench

Round-robin scheduler that shares one 32-bit ALU (operands `a`/`b`, 3-bit `op`, `en`, `res`, `ack`) among `NREQ` requesters. Each requester presents an operand pair and opcode, and the scheduler grants one requester at a time. It drives the ALU until `ack`, then returns the result to the granted requester. It sits between the requesting datapath units and the single ALU instance.

---
 rtl/alu_rr_sched_pkg.sv | 30 +++
 rtl/alu_rr_sched_if.sv | 42 ++++
 rtl/alu_rr_sched_rr_arbiter.sv | 55 +++++
 rtl/alu_rr_sched.sv | 131 +++++++++++++
 tb/tb_alu_rr_sched.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_sched_pkg.sv
// +----------------------------------------------------------------------+
// | alu_sched_pkg : shared types and constants for the ALU RR scheduler  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_sched_pkg;

    localparam int ALU_OP_W     = 3;
    localparam int ALU_W        = 32;
    localparam int DEFAULT_NREQ = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_rr_sched_if.sv
// +----------------------------------------------------------------------+
// | alu_rr_sched_if : requester and ALU signals of the RR scheduler      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_rr_sched_if
    import alu_sched_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = ALU_W
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*W-1:0]        req_a;
    logic [NREQ*W-1:0]        req_b;
    logic [NREQ*ALU_OP_W-1:0] req_op;
    logic [NREQ-1:0]          rsp_valid;
    logic [W-1:0]             rsp_res;
    logic                     rsp_err;
    logic [W-1:0]             alu_a;
    logic [W-1:0]             alu_b;
    logic [ALU_OP_W-1:0]      alu_op;
    logic                     alu_en;
    logic [W-1:0]             alu_res;
    logic                     alu_ack;

    // Requesters plus the ALU instance
    modport master (
        output req_valid, req_a, req_b, req_op, alu_res, alu_ack,
        input  req_ready, rsp_valid, rsp_res, rsp_err, alu_a, alu_b, alu_op, alu_en
    );

    // The scheduler
    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_res, alu_ack,
        output req_ready, rsp_valid, rsp_res, rsp_err, alu_a, alu_b, alu_op, alu_en
    );

endinterface

`default_nettype wire

// File: rtl/alu_rr_sched_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin pick starting at ptr, ptr advances on accept|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0] gnt_id_o
);
    logic [ID_W-1:0] ptr_q;

    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_v;
        logic        found;
        gnt_oh_o = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        idx_v    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = ID_W'(idx);
            if (!found && req_valid_i[idx_v]) begin
                found           = 1'b1;
                gnt_id_o        = idx_v;
                gnt_oh_o[idx_v] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= (gnt_id_o == ID_W'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rr_sched.sv
// +----------------------------------------------------------------------+
// | alu_rr_sched : shares one ALU among NREQ requesters, round-robin.    |
// | Optional ack watchdog: ALU_SCHED_TIMEOUT_EN.  Rev 1.0                |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ       = DEFAULT_NREQ,
    parameter int W          = ALU_W,
    parameter int TMO_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_rr_sched_if.slave bus
);
    localparam int ID_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYCLES < 1) begin : g_bad_cfg
        $error("alu_rr_sched: unsupported parameter values");
    end

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     gnt_id;
    logic [NREQ-1:0]     gnt_oh;
    logic                accept;
    logic                tmo;
    logic [W-1:0]        a_q, b_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [W-1:0]        res_q, res_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (bus.req_valid),
        .accept_i    (accept),
        .gnt_oh_o    (gnt_oh),
        .gnt_id_o    (gnt_id)
    );

    // A non-zero pick implies its valid bit is set, so ready&valid == accept
    assign accept        = (state_q == ST_IDLE) && !rst && (|gnt_oh);
    assign bus.req_ready = accept ? gnt_oh : '0;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign tmo = (cnt_q == CNT_W'(TMO_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == ST_BUSY && (bus.alu_ack || tmo)) begin
                err_q <= !bus.alu_ack;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign tmo         = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: begin
                // Ack beats the watchdog when both land on the same cycle
                if (bus.alu_ack) begin
                    res_d   = bus.alu_res;
                    state_d = ST_RESP;
                end else if (tmo) begin
                    res_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (accept) begin
                id_q <= gnt_id;
                a_q  <= bus.req_a[int'(gnt_id)*W +: W];
                b_q  <= bus.req_b[int'(gnt_id)*W +: W];
                op_q <= bus.req_op[int'(gnt_id)*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_en    = (state_q == ST_BUSY);
    assign bus.rsp_valid = (state_q == ST_RESP) ? (NREQ'(1) << id_q) : '0;
    assign bus.rsp_res   = res_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
// +----------------------------------------------------------------------+
// | tb_alu_rr_sched : directed + randomized bench with an ALU model and  |
// | a round-robin reference.  Rev 1.0                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_rr_sched;
    import alu_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int TMO  = 16;

    logic clk;
    logic rst;
    logic [NREQ-1:0]     vmask;
    logic [W-1:0]        ta  [NREQ];
    logic [W-1:0]        tbv [NREQ];
    logic [ALU_OP_W-1:0] top [NREQ];
    int                  ack_delay;
    logic                force_ack;
    int                  busy_cnt;
    int                  checks;
    int                  errors;
    int                  exp_ptr;

    alu_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_rr_sched #(
        .NREQ       (NREQ),
        .W          (W),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [ALU_OP_W-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            default: return b;
        endcase
    endfunction

    // ALU model: acks after ack_delay extra BUSY cycles
    assign bus.req_valid = vmask;
    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign bus.req_a[i*W +: W]                = ta[i];
        assign bus.req_b[i*W +: W]                = tbv[i];
        assign bus.req_op[i*ALU_OP_W +: ALU_OP_W] = top[i];
    end
    assign bus.alu_res = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_ack = force_ack | (bus.alu_en && (busy_cnt >= ack_delay));

    always @(posedge clk) begin
        if (bus.alu_en !== 1'b1 || bus.alu_ack === 1'b1) busy_cnt <= 0;
        else busy_cnt <= busy_cnt + 1;
    end

    // Reference arbiter: nearest valid requester at or after ptr, cyclically
    function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                int d = (i - p + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call with inputs settled in an IDLE cycle; runs one full operation
    task automatic serve(input int fixed_g, input int ack_d, input bit exp_err, input int exp_lat);
        int want, g, cyc, en_cnt;
        logic [W-1:0] ea, eb, eres;
        logic [ALU_OP_W-1:0] eo;
        want = model_pick(vmask, exp_ptr);
        check("req_ready", 64'(bus.req_ready), 64'(onehot(want)));
        g = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i] === 1'b1 && g < 0) g = i;
        if (fixed_g >= 0) check("grant_order", 64'(g), 64'(fixed_g));
        if (want < 0) return;
        ea   = ta[want];
        eb   = tbv[want];
        eo   = top[want];
        eres = exp_err ? '0 : alu_fn(ea, eb, eo);
        ack_delay = ack_d;
        tick();
        cyc    = 1;
        en_cnt = 0;
        check("alu_op_latched", 64'(bus.alu_op), 64'(eo));
        while (bus.rsp_valid === '0 && cyc < 40) begin
            if (bus.alu_en === 1'b1) en_cnt++;
            check("alu_operands", {bus.alu_a, bus.alu_b}, {ea, eb});
            tick();
            cyc++;
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(want)));
        check("rsp_latency", 64'(cyc), 64'(exp_lat));
        check("alu_en_cycles", 64'(en_cnt), 64'(exp_lat - 1));
        check("rsp_res", 64'(bus.rsp_res), 64'(eres));
        check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        check("alu_en_resp", 64'(bus.alu_en), 64'd0);
        exp_ptr = (want + 1) % NREQ;
        tick();
        check("rsp_single", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_ptr   = 0;
        ack_delay = 0;
        force_ack = 1'b0;
        busy_cnt  = 0;
        vmask     = '1;
        for (int i = 0; i < NREQ; i++) begin
            ta[i]  = '0;
            tbv[i] = '0;
            top[i] = '0;
        end

        // Reset, with every requester asking: nothing may be granted
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_alu_en", 64'(bus.alu_en), 64'd0);
        check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        rst   = 1'b0;
        vmask = '0;
        tick();

        // Single request on requester 0
        ta[0] = 32'h0000_00FF; tbv[0] = 32'h0000_000F; top[0] = OP_ADD;
        vmask = 4'b0001;
        #1;
        serve(0, 0, 1'b0, 2);

        // Ack delayed by 5 cycles on requester 1
        ta[1] = 32'h1234_5678; tbv[1] = 32'h0000_0004; top[1] = OP_SLL;
        vmask = 4'b0010;
        #1;
        serve(1, 5, 1'b0, 7);

        // Spurious ack while idle
        vmask     = '0;
        force_ack = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("spur_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("spur_alu_en", 64'(bus.alu_en), 64'd0);
        end
        force_ack = 1'b0;
        ta[3] = 32'hDEAD_BEEF; tbv[3] = 32'h0F0F_0F0F; top[3] = OP_XOR;
        vmask = 4'b1000;
        #1;
        serve(3, 0, 1'b0, 2);

        // Reset pulsed on the 2nd BUSY cycle
        ta[2] = 32'h0000_0011; tbv[2] = 32'h0000_0022; top[2] = OP_OR;
        vmask     = 4'b0100;
        ack_delay = 1000;
        #1;
        check("rb_ready", 64'(bus.req_ready), 64'(onehot(model_pick(vmask, exp_ptr))));
        tick();
        check("rb_busy1", 64'(bus.alu_en), 64'd1);
        tick();
        check("rb_busy2", 64'(bus.alu_en), 64'd1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        vmask = '0;
        check("rb_alu_en", 64'(bus.alu_en), 64'd0);
        check("rb_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("rb_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        exp_ptr   = 0;
        ack_delay = 0;

        // All four held: 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) begin
            ta[i]  = 32'h100 * (i + 1);
            tbv[i] = 32'h7 + i;
            top[i] = ALU_OP_W'(i + 1);
        end
        vmask = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            serve(n % NREQ, 0, 1'b0, 2);
        end

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            int d;
            for (int i = 0; i < NREQ; i++) begin
                ta[i]  = $urandom;
                tbv[i] = $urandom;
                top[i] = ALU_OP_W'($urandom_range(0, 7));
            end
            vmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            d     = int'($urandom_range(0, 3));
            #1;
            serve(-1, d, 1'b0, d + 2);
        end
        vmask = '0;

`ifdef ALU_SCHED_TIMEOUT_EN
        // Ack never arrives: watchdog fires after TMO BUSY cycles
        ta[1] = 32'hCAFE_0001; tbv[1] = 32'h0000_0002; top[1] = OP_ADD;
        vmask = 4'b0010;
        #1;
        serve(1, 1000, 1'b1, TMO + 1);
        vmask = '0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
